// File: rtl/lcd_reg_responder.sv
// Bus-side register responder for the LCD command path: decodes CPU writes into
// window/colour registers and queues display commands to the LCD driver.
module lcd_reg_responder #(
    parameter int MAX_X      = 240,
    parameter int MAX_Y      = 320,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_strobe,
    input  logic [31:0]                   address,
    input  logic [31:0]                   data,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_op,
    output logic [15:0]                   cmd_x0,
    output logic [15:0]                   cmd_x1,
    output logic [15:0]                   cmd_y0,
    output logic [15:0]                   cmd_y1,
    output logic [15:0]                   cmd_color,
    output logic                          disp_on,
    output logic                          ovf_err,
    output logic                          win_err,
    output logic                          addr_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [31:0]   ADDR_CTRL = 32'd4;
    localparam logic [31:0]   ADDR_XWIN = 32'd8;
    localparam logic [31:0]   ADDR_YWIN = 32'd12;
    localparam logic [31:0]   ADDR_SCLR = 32'd16;
    localparam logic [15:0]   MAX_X16   = 16'(MAX_X);
    localparam logic [15:0]   MAX_Y16   = 16'(MAX_Y);
    localparam logic [15:0]   X_END     = 16'(MAX_X - 1);
    localparam logic [15:0]   Y_END     = 16'(MAX_Y - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        OP_NONE     = 3'd0,
        OP_SWRESET  = 3'd1,
        OP_DISP_ON  = 3'd2,
        OP_DISP_OFF = 3'd3,
        OP_FILL     = 3'd4
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] y0;
        logic [15:0] y1;
        logic [15:0] color;
    } cmd_t;

    logic [15:0]   x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [15:0]   color_q, color_d;
    logic          disp_on_q, disp_on_d;
    logic          ovf_q, ovf_d, win_q, win_d, addr_q, addr_d;
    cmd_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    logic          push, push_ok, pop;
    cmd_t          push_cmd;
    cmd_t          head;

    // NOTE: every signal gets a default before the decode so no path leaves it unassigned (no latch).
    always_comb begin
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        color_d   = color_q;
        disp_on_d = disp_on_q;
        ovf_d     = ovf_q;
        win_d     = win_q;
        addr_d    = addr_q;
        push      = 1'b0;
        push_cmd  = '{OP_NONE, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

        if (wr_strobe) begin
            case (address)
                ADDR_CTRL: begin
                    // Highest set bit wins; lower bits in the same write are ignored.
                    if (data[8]) begin
                        push     = 1'b1;
                        push_cmd = '{OP_FILL, 16'd0, X_END, 16'd0, Y_END, 16'h0000};
                    end else if (data[7]) begin
                        push      = 1'b1;
                        push_cmd  = '{OP_SWRESET, x0_q, x1_q, y0_q, y1_q, color_q};
                        x0_d      = 16'd0;
                        x1_d      = X_END;
                        y0_d      = 16'd0;
                        y1_d      = Y_END;
                        color_d   = 16'h0000;
                        disp_on_d = 1'b0;
                    end else if (data[6]) begin
                        push      = 1'b1;
                        push_cmd  = '{OP_DISP_ON, x0_q, x1_q, y0_q, y1_q, color_q};
                        disp_on_d = 1'b1;
                    end else if (data[5]) begin
                        push      = 1'b1;
                        push_cmd  = '{OP_DISP_OFF, x0_q, x1_q, y0_q, y1_q, color_q};
                        disp_on_d = 1'b0;
                    end else if (|data[4:0]) begin
                        if (data[4])      color_d = 16'hF800;
                        else if (data[3]) color_d = 16'h07E0;
                        else if (data[2]) color_d = 16'h001F;
                        else if (data[1]) color_d = 16'hFFFF;
                        else              color_d = 16'h0000;
                        push     = 1'b1;
                        push_cmd = '{OP_FILL, x0_q, x1_q, y0_q, y1_q, color_d};
                    end
                end
                ADDR_XWIN: begin
                    if (data[31:16] <= data[15:0] && data[15:0] < MAX_X16) begin
                        x0_d = data[31:16];
                        x1_d = data[15:0];
                    end else begin
                        win_d = 1'b1;
                    end
                end
                ADDR_YWIN: begin
                    if (data[31:16] <= data[15:0] && data[15:0] < MAX_Y16) begin
                        y0_d = data[31:16];
                        y1_d = data[15:0];
                    end else begin
                        win_d = 1'b1;
                    end
                end
                ADDR_SCLR: begin
                    ovf_d  = 1'b0;
                    win_d  = 1'b0;
                    addr_d = 1'b0;
                end
                default: addr_d = 1'b1;
            endcase
        end

        // A full FIFO still accepts a push when the head leaves in the same cycle.
        pop     = (level_q != '0) && cmd_ready;
        push_ok = push && ((level_q != DEPTH_L) || pop);
        if (push && !push_ok) ovf_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q      <= 16'd0;
            x1_q      <= X_END;
            y0_q      <= 16'd0;
            y1_q      <= Y_END;
            color_q   <= 16'h0000;
            disp_on_q <= 1'b0;
            ovf_q     <= 1'b0;
            win_q     <= 1'b0;
            addr_q    <= 1'b0;
        end else begin
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            color_q   <= color_d;
            disp_on_q <= disp_on_d;
            ovf_q     <= ovf_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
        end
    end

    // NOTE: the FIFO storage is reset because the head entry drives cmd_* directly and must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '{OP_NONE, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_cmd;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign cmd_valid  = (level_q != '0);
    assign cmd_op     = head.op;
    assign cmd_x0     = head.x0;
    assign cmd_x1     = head.x1;
    assign cmd_y0     = head.y0;
    assign cmd_y1     = head.y1;
    assign cmd_color  = head.color;
    assign disp_on    = disp_on_q;
    assign ovf_err    = ovf_q;
    assign win_err    = win_q;
    assign addr_err   = addr_q;
    assign fifo_level = level_q;

endmodule
